// File: rtl/tsv_bist_2_2_pkg.sv
// Shared constants, FSM state type and popcount helper for the 2+2 TSV BIST.
package tsv_bist_2_2_pkg;

  localparam int unsigned NTSV_2_2       = 4;
  localparam int unsigned SETTLE_CYC_2_2 = 2;
  localparam int unsigned MAX_FAULTS_2_2 = 2;

  // Widest flag vector the popcount helper accepts.
  localparam int unsigned POP_W = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } bist_state_e;

  // Number of set bits; callers zero-extend their vector to POP_W.
  function automatic logic [7:0] popcount(input logic [POP_W-1:0] v);
    logic [7:0] c;
    c = '0;
    for (int unsigned i = 0; i < POP_W; i++) begin
      c = c + 8'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/tsv_bist_2_2_if.sv
// Control / TSV-side bundle of the BIST controller.
interface tsv_bist_2_2_if #(
  parameter int unsigned NTSV = 4
) ();

  localparam int unsigned CNT_W = $clog2(NTSV + 1);

  logic             start;
  logic [NTSV-1:0]  tsv_rx;
  logic             test_mode;
  logic [NTSV-1:0]  test_tsv_out;
  logic             busy;
  logic             done;
  logic [NTSV-1:0]  f_flag;
  logic [CNT_W-1:0] fault_cnt;
  logic             repair_fail;

  // Requester / link side.
  modport master (
    output start, tsv_rx,
    input  test_mode, test_tsv_out, busy, done, f_flag, fault_cnt, repair_fail
  );

  // BIST controller side.
  modport slave (
    input  start, tsv_rx,
    output test_mode, test_tsv_out, busy, done, f_flag, fault_cnt, repair_fail
  );

endinterface

// File: rtl/tsv_bist_patgen.sv
// Walking-one then walking-zero pattern for a given pattern index.
module tsv_bist_patgen #(
  parameter int unsigned NTSV  = 4,
  parameter int unsigned IDX_W = 3
) (
  input  logic [IDX_W-1:0] pat_idx_i,
  output logic [NTSV-1:0]  pattern_o
);

  // Index below NTSV selects the single set bit, otherwise the single cleared bit.
  always_comb begin
    pattern_o = '0;
    for (int unsigned i = 0; i < NTSV; i++) begin
      if (32'(pat_idx_i) < NTSV) begin
        pattern_o[i] = (32'(pat_idx_i) == i);
      end else begin
        pattern_o[i] = ((32'(pat_idx_i) - NTSV) != i);
      end
    end
  end

endmodule

// File: rtl/tsv_bist_2_2.sv
// BIST controller: walks 1s and 0s across the TSV bundle and publishes per-TSV fault flags.
module tsv_bist_2_2
  import tsv_bist_2_2_pkg::*;
#(
  parameter int unsigned NTSV       = NTSV_2_2,
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_2_2,
  parameter int unsigned MAX_FAULTS = MAX_FAULTS_2_2
) (
  input  logic           clock,
  input  logic           reset_n,
  tsv_bist_2_2_if.slave  bus
);

  localparam int unsigned NPAT  = 2 * NTSV;
  localparam int unsigned IDX_W = $clog2(NPAT);
  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned CNT_W = $clog2(NTSV + 1);

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NPAT - 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

  bist_state_e      state_q, state_d;
  logic [IDX_W-1:0] pat_idx_q, pat_idx_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [NTSV-1:0]  scratch_q, scratch_d;

  logic             test_mode_q, test_mode_d;
  logic [NTSV-1:0]  tsv_out_q, tsv_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [NTSV-1:0]  f_flag_q, f_flag_d;
  logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;
  logic             repair_fail_q, repair_fail_d;

  logic [NTSV-1:0]  pattern_nxt;
  logic             drive_nxt;

  // Pattern for the index the controller will be at after this edge.
  tsv_bist_patgen #(
    .NTSV  (NTSV),
    .IDX_W (IDX_W)
  ) u_patgen (
    .pat_idx_i (pat_idx_d),
    .pattern_o (pattern_nxt)
  );

  // State register and all registered outputs; synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pat_idx_q     <= '0;
      settle_q      <= '0;
      scratch_q     <= '0;
      test_mode_q   <= 1'b0;
      tsv_out_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      f_flag_q      <= '0;
      fault_cnt_q   <= '0;
      repair_fail_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pat_idx_q     <= pat_idx_d;
      settle_q      <= settle_d;
      scratch_q     <= scratch_d;
      test_mode_q   <= test_mode_d;
      tsv_out_q     <= tsv_out_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      f_flag_q      <= f_flag_d;
      fault_cnt_q   <= fault_cnt_d;
      repair_fail_q <= repair_fail_d;
    end
  end

  // Next-state logic; flags are only replaced on the final SAMPLE -> DONE step.
  always_comb begin
    state_d   = state_q;
    pat_idx_d = pat_idx_q;
    settle_d  = settle_q;
    scratch_d = scratch_q;
    f_flag_d  = f_flag_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = DRIVE;
          pat_idx_d = '0;
          settle_d  = '0;
          scratch_d = '0;
        end
      end
      DRIVE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      SAMPLE: begin
        // tsv_out_q still carries the pattern for pat_idx_q here.
        scratch_d = scratch_q | (bus.tsv_rx ^ tsv_out_q);
        if (pat_idx_q == LAST_IDX) begin
          state_d  = DONE;
          f_flag_d = scratch_d;
          done_d   = 1'b1;
        end else begin
          state_d   = DRIVE;
          pat_idx_d = pat_idx_q + IDX_W'(1);
          settle_d  = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered-output decode from the upcoming state.
  always_comb begin
    drive_nxt     = (state_d == DRIVE) || (state_d == SAMPLE);
    test_mode_d   = drive_nxt;
    busy_d        = drive_nxt;
    tsv_out_d     = drive_nxt ? pattern_nxt : '0;
    fault_cnt_d   = CNT_W'(popcount(POP_W'(f_flag_d)));
    repair_fail_d = (32'(fault_cnt_d) > MAX_FAULTS);
  end

  assign bus.test_mode    = test_mode_q;
  assign bus.test_tsv_out = tsv_out_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.f_flag       = f_flag_q;
  assign bus.fault_cnt    = fault_cnt_q;
  assign bus.repair_fail  = repair_fail_q;

endmodule

// File: tb/tb_tsv_bist_2_2.sv
// Self-checking bench for tsv_bist_2_2 with a run-age reference model and fault injection.
module tb_tsv_bist_2_2;

  localparam int unsigned NTSV   = 4;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned PER    = SETTLE + 1;
  localparam int          RUN    = 2 * NTSV * PER;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] sa0 = '0;
  logic [3:0] sa1 = '0;
  logic       bridge = 1'b0;

  tsv_bist_2_2_if #(.NTSV(NTSV)) bus ();

  tsv_bist_2_2 #(
    .NTSV       (NTSV),
    .SETTLE_CYC (SETTLE),
    .MAX_FAULTS (2)
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else passed++;
  endtask

  // Physical link: wired-OR bridge TSV1-TSV2, then stuck-at faults.
  function automatic logic [3:0] line_fn(input logic [3:0] d, input logic [3:0] s0,
                                         input logic [3:0] s1, input logic br);
    logic [3:0] r;
    r = d;
    if (br) begin
      r[1] = d[1] | d[2];
      r[2] = d[1] | d[2];
    end
    return (r & ~s0) | s1;
  endfunction

  function automatic logic [3:0] pat(input int k);
    logic [3:0] one;
    one = 4'b0001;
    if (k < NTSV) return one << k;
    return ~(one << (k - NTSV));
  endfunction

  always_comb bus.tsv_rx = line_fn(bus.test_tsv_out, sa0, sa1, bridge);

  // Reference model: age 0 = idle, 1..RUN = run cycle number, RUN+1 = result cycle.
  int         age = 0;
  logic [3:0] acc = '0;
  logic [3:0] m_flag = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      age = 0; acc = '0; m_flag = '0;
    end else if (age == 0) begin
      if (bus.start === 1'b1) begin age = 1; acc = '0; end
    end else if (age == RUN + 1) begin
      age = 0;
    end else begin
      if (age % PER == 0) acc |= line_fn(pat(age / PER - 1), sa0, sa1, bridge) ^ pat(age / PER - 1);
      age++;
      if (age == RUN + 1) m_flag = acc;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic run;
      run = (age >= 1) && (age <= RUN);
      chk("busy", 32'(bus.busy), 32'(run));
      chk("test_mode", 32'(bus.test_mode), 32'(run));
      chk("tsv_out", 32'(bus.test_tsv_out), run ? 32'(pat((age - 1) / PER)) : 32'd0);
      chk("done", 32'(bus.done), 32'(age == RUN + 1));
      chk("f_flag", 32'(bus.f_flag), 32'(m_flag));
      chk("fault_cnt", 32'(bus.fault_cnt), 32'($countones(m_flag)));
      chk("repair_fail", 32'(bus.repair_fail), 32'($countones(m_flag) > 2));
    end
  end

  // Pulse start from idle and return the cycle number in which done rises.
  task automatic run_once(output int lat);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk); lat++;
    end
  endtask

  task automatic expect_result(input string nm, input logic [3:0] f, input int cnt, input logic rf);
    chk({nm, "_flag"}, 32'(bus.f_flag), 32'(f));
    chk({nm, "_cnt"}, 32'(bus.fault_cnt), 32'(cnt));
    chk({nm, "_rf"}, 32'(bus.repair_fail), 32'(rf));
  endtask

  initial begin
    int lat;
    int dones;
    bus.start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_tm", 32'(bus.test_mode), 32'd0);
    chk("rst_flag", 32'(bus.f_flag), 32'd0);
    chk("rst_out", 32'(bus.test_tsv_out), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Fault-free loopback.
    run_once(lat);
    chk("lat_clean", 32'(lat), 32'd25);
    expect_result("clean", 4'b0000, 0, 1'b0);

    // TSV2 stuck-at-1.
    sa1 = 4'b0100;
    run_once(lat);
    chk("lat_sa1", 32'(lat), 32'd25);
    expect_result("sa1_t2", 4'b0100, 1, 1'b0);

    // TSV0 stuck-at-0 plus TSV3 stuck-at-1.
    sa0 = 4'b0001; sa1 = 4'b1000;
    run_once(lat);
    expect_result("t0t3", 4'b1001, 2, 1'b0);

    // Bridge TSV1-TSV2, then with TSV0 stuck-at-0 added.
    sa0 = '0; sa1 = '0; bridge = 1'b1;
    run_once(lat);
    expect_result("bridge", 4'b0110, 2, 1'b0);
    sa0 = 4'b0001;
    run_once(lat);
    expect_result("bridge_t0", 4'b0111, 3, 1'b1);

    // Reset during cycle 10 of a run aborts with no result.
    sa0 = '0; bridge = 1'b0;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("abort_tm", 32'(bus.test_mode), 32'd0);
    chk("abort_flag", 32'(bus.f_flag), 32'd0);
    dones = 0;
    repeat (30) begin @(negedge clk); if (bus.done === 1'b1) dones++; end
    chk("abort_nodone", 32'(dones), 32'd0);
    run_once(lat);
    chk("lat_after_abort", 32'(lat), 32'd25);

    // Start re-pulsed mid-run is ignored; second run replaces flags.
    sa1 = 4'b0100;
    @(negedge clk); bus.start = 1'b1;
    lat = 0; dones = 0;
    for (int n = 1; n <= 35; n++) begin
      @(negedge clk);
      bus.start = (n == 5 || n == 12);
      if (bus.done === 1'b1) begin dones++; lat = n; end
    end
    bus.start = 1'b0;
    chk("repulse_dones", 32'(dones), 32'd1);
    chk("repulse_lat", 32'(lat), 32'd25);
    chk("repulse_flag", 32'(bus.f_flag), 32'(4'b0100));
    sa1 = '0;
    run_once(lat);
    expect_result("cleared", 4'b0000, 0, 1'b0);

    // Randomised starts, faults and occasional resets against the model.
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 39) == 0) begin
        sa0 = 4'($urandom); sa1 = 4'($urandom) & ~sa0; bridge = 1'($urandom);
      end
      rst_n = ($urandom_range(0, 149) != 0);
    end
    bus.start = 1'b0;
    rst_n = 1'b1;
    repeat (30) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
